// File: rtl/route_pkg.sv
// Package shared by the route-compute pipeline.
// Contents:
//   CORE_PORT     - index of the local core port in the one-hot port vector
//   MAX_ADDR_W    - widest destination address the helpers support
//   MAX_FLIT_W    - widest flit the helpers support
//   flit_dest     - extract the dest field (LSBs) of a flit
//   flit_payload  - extract the payload field (MSBs) of a flit
//   route_onehot  - dest/node compare giving the one-hot output port
// The helpers work on fixed maximum widths so that any parametrisation of
// the pipeline can share them; callers size-cast arguments and results.
package route_pkg;

  localparam int CORE_PORT  = 0;
  localparam int MAX_ADDR_W = 32;
  localparam int MAX_FLIT_W = 256;

  function automatic logic [MAX_ADDR_W-1:0] flit_dest(
    input logic [MAX_FLIT_W-1:0] flit,
    input int                    addr_w
  );
    logic [MAX_FLIT_W-1:0] mask;
    mask = (MAX_FLIT_W'(1) << addr_w) - MAX_FLIT_W'(1);
    return MAX_ADDR_W'(flit & mask);
  endfunction

  function automatic logic [MAX_FLIT_W-1:0] flit_payload(
    input logic [MAX_FLIT_W-1:0] flit,
    input int                    addr_w
  );
    return flit >> addr_w;
  endfunction

  // Bit 0 is the core; bit i+1 is router port i, where i is the lowest
  // address bit in which dest and node differ.
  function automatic logic [MAX_ADDR_W:0] route_onehot(
    input logic [MAX_ADDR_W-1:0] dest,
    input logic [MAX_ADDR_W-1:0] node,
    input int                    addr_w
  );
    logic [MAX_ADDR_W-1:0] diff;
    logic [MAX_ADDR_W:0]   onehot;
    logic                  found;
    diff   = dest ^ node;
    onehot = '0;
    found  = 1'b0;
    for (int i = 0; i < MAX_ADDR_W; i++) begin
      if (!found && (i < addr_w) && diff[i]) begin
        onehot[i+1] = 1'b1;
        found       = 1'b1;
      end
    end
    if (!found) begin
      onehot[CORE_PORT] = 1'b1;
    end
    return onehot;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO used as the input buffer of the route-compute pipeline.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   push, wdata  - write request and data (ignored while full)
//   pop          - read request (ignored while empty)
//   rdata        - current head entry, valid while !empty
//   full, empty  - occupancy flags, decoded from the registered count
//   count        - current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
  import route_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign rdata  = mem[rdPtr_q];
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
  // the count untouched.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + PTR_W'(1);
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + PTR_W'(1);
    end
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr_q] <= wdata;
    end
  end

endmodule

// File: rtl/route_compute_pipe.sv
// Route-compute stage of the NoC router: buffers incoming flits in a FIFO,
// decodes the output port of the FIFO head and presents it on a registered
// output stage with a one-hot per-port valid.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   in_valid    - input flit valid
//   in_ready    - input can accept (FIFO not full, from registered count)
//   in_flit     - input flit {payload, dest}, dest in the LSBs
//   out_valid   - one-hot port request; bit 0 core, bit i+1 router port i
//   out_ready   - per-port ready; only the addressed bit matters
//   out_flit    - flit held in the output stage
//   fifo_count  - input FIFO occupancy
module route_compute_pipe
  import route_pkg::*;
#(
  parameter int              ADDR_W    = 4,
  parameter int              DATA_W    = 7,
  parameter logic [ADDR_W-1:0] NODE_ADDR = '0,
  parameter int              DEPTH     = 4,
  localparam int             FLIT_W    = DATA_W + ADDR_W,
  localparam int             CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FLIT_W-1:0] in_flit,
  output logic [ADDR_W:0]   out_valid,
  input  logic [ADDR_W:0]   out_ready,
  output logic [FLIT_W-1:0] out_flit,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic              fifoFull;
  logic              fifoEmpty;
  logic              fifoPush;
  logic              fifoPop;
  logic [FLIT_W-1:0] headFlit;
  logic [ADDR_W:0]   decodedPort;
  logic              xfer;

  logic [0:0]        state_q, state_d;
  logic [FLIT_W-1:0] outFlit_q, outFlit_d;
  logic [ADDR_W:0]   outPort_q, outPort_d;

  // in_ready comes only from the registered count, so a pop in the same
  // cycle never reopens a full FIFO and out_ready cannot reach in_ready.
  assign in_ready = !fifoFull;
  assign fifoPush = in_valid && !fifoFull;

  sync_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifoPush),
    .pop   (fifoPop),
    .wdata (in_flit),
    .rdata (headFlit),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifo_count)
  );

  assign decodedPort = (ADDR_W+1)'(route_onehot(
                         flit_dest(MAX_FLIT_W'(headFlit), ADDR_W),
                         MAX_ADDR_W'(NODE_ADDR),
                         ADDR_W));

  // The stored port is all-zero while idle, so it doubles as out_valid and
  // masks readiness on every port the current flit is not addressed to.
  assign out_valid = outPort_q;
  assign out_flit  = outFlit_q;
  assign xfer      = |(outPort_q & out_ready);

  // Output stage: load from the FIFO when idle, or in the same cycle the
  // held flit is accepted so back-to-back flits stream at one per cycle.
  always_comb begin
    state_d   = state_q;
    outFlit_d = outFlit_q;
    outPort_d = outPort_q;
    fifoPop   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (!fifoEmpty) begin
        fifoPop   = 1'b1;
        outFlit_d = headFlit;
        outPort_d = decodedPort;
        state_d   = ST_HOLD;
      end
    end else begin
      if (xfer) begin
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          outFlit_d = headFlit;
          outPort_d = decodedPort;
        end else begin
          outPort_d = '0;
          state_d   = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      outFlit_q <= '0;
      outPort_q <= '0;
    end else begin
      state_q   <= state_d;
      outFlit_q <= outFlit_d;
      outPort_q <= outPort_d;
    end
  end

endmodule

// File: tb/tb_route_compute_pipe.sv
// Self-checking bench for route_compute_pipe. Two instances share clock and
// reset: unit 0 has node address 0000, unit 1 has node address 0101.
// Inputs are driven and outputs sampled at the falling edge.
module tb_route_compute_pipe;

  localparam int AW  = 4;
  localparam int DW  = 7;
  localparam int FW  = AW + DW;
  localparam int DEP = 4;

  logic          clk;
  logic          rst;
  logic          inValid  [2];
  logic [FW-1:0] inFlit   [2];
  logic [AW:0]   outReady [2];
  logic          inReady  [2];
  logic [AW:0]   outValid [2];
  logic [FW-1:0] outFlit  [2];
  logic [2:0]    fifoCount[2];

  int total;
  int bad;

  route_compute_pipe #(
    .ADDR_W(AW), .DATA_W(DW), .NODE_ADDR(4'b0000), .DEPTH(DEP)
  ) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(inValid[0]), .in_ready(inReady[0]), .in_flit(inFlit[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .out_flit(outFlit[0]),
    .fifo_count(fifoCount[0])
  );

  route_compute_pipe #(
    .ADDR_W(AW), .DATA_W(DW), .NODE_ADDR(4'b0101), .DEPTH(DEP)
  ) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(inValid[1]), .in_ready(inReady[1]), .in_flit(inFlit[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .out_flit(outFlit[1]),
    .fifo_count(fifoCount[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] nodeOf(input int u);
    return (u == 0) ? 4'b0000 : 4'b0101;
  endfunction

  // Port chosen by the routing rule: core on a match, else one past the
  // position of the lowest differing address bit.
  function automatic logic [AW:0] refPort(input logic [3:0] dest, input logic [3:0] node);
    int x;
    int p;
    x = int'(dest ^ node);
    if (x == 0) return 5'b00001;
    p = 0;
    while (x % 2 == 0) begin
      x = x / 2;
      p++;
    end
    return 5'(1 << (p + 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      total++;
      if (inReady[u] !== 1'b1) begin
        bad++; $display("[TB] FAIL reset_in_ready u%0d: got %b want 1", u, inReady[u]);
      end
      total++;
      if (outValid[u] !== 5'b0) begin
        bad++; $display("[TB] FAIL reset_out_valid u%0d: got %b want 00000", u, outValid[u]);
      end
      total++;
      if (outFlit[u] !== 11'b0) begin
        bad++; $display("[TB] FAIL reset_out_flit u%0d: got %h want 000", u, outFlit[u]);
      end
      total++;
      if (fifoCount[u] !== 3'd0) begin
        bad++; $display("[TB] FAIL reset_fifo_count u%0d: got %0d want 0", u, fifoCount[u]);
      end
    end
  endtask

  task automatic test_core_delivery();
    logic [FW-1:0] f;
    f = {7'b1111000, 4'b0000};
    outReady[0] = 5'b11111;
    inValid[0]  = 1'b1;
    inFlit[0]   = f;
    tick();
    inValid[0] = 1'b0;
    total++;
    if (outValid[0] !== 5'b00000) begin
      bad++; $display("[TB] FAIL core_early_valid: got %b want 00000", outValid[0]);
    end
    total++;
    if (fifoCount[0] !== 3'd1) begin
      bad++; $display("[TB] FAIL core_count: got %0d want 1", fifoCount[0]);
    end
    tick();
    total++;
    if (outValid[0] !== 5'b00001) begin
      bad++; $display("[TB] FAIL core_valid: got %b want 00001", outValid[0]);
    end
    total++;
    if (outFlit[0] !== 11'b1111000_0000) begin
      bad++; $display("[TB] FAIL core_flit: got %b want 11110000000", outFlit[0]);
    end
    tick();
    total++;
    if (outValid[0] !== 5'b00000) begin
      bad++; $display("[TB] FAIL core_drained: got %b want 00000", outValid[0]);
    end
  endtask

  task automatic test_lowest_bit();
    logic [3:0]    dests [5];
    logic [AW:0]   exps  [5];
    logic [FW-1:0] f;
    dests = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0110};
    exps  = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00100};
    outReady[0] = 5'b11111;
    for (int k = 0; k < 5; k++) begin
      f = {7'($urandom), dests[k]};
      inValid[0] = 1'b1;
      inFlit[0]  = f;
      tick();
      inValid[0] = 1'b0;
      tick();
      total++;
      if (outValid[0] !== exps[k]) begin
        bad++; $display("[TB] FAIL lowbit_valid dest=%b: got %b want %b", dests[k], outValid[0], exps[k]);
      end
      total++;
      if (outFlit[0] !== f) begin
        bad++; $display("[TB] FAIL lowbit_flit dest=%b: got %h want %h", dests[k], outFlit[0], f);
      end
      tick();
    end
  endtask

  task automatic test_nonzero_node();
    logic [3:0]    dests [6];
    logic [AW:0]   want;
    logic [FW-1:0] f;
    dests = '{4'b0101, 4'b0111, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom)};
    outReady[1] = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      if (k == 0)      want = 5'b00001;
      else if (k == 1) want = 5'b00100;
      else             want = refPort(dests[k], 4'b0101);
      f = {7'($urandom), dests[k]};
      inValid[1] = 1'b1;
      inFlit[1]  = f;
      tick();
      inValid[1] = 1'b0;
      tick();
      total++;
      if (outValid[1] !== want) begin
        bad++; $display("[TB] FAIL node5_valid dest=%b: got %b want %b", dests[k], outValid[1], want);
      end
      total++;
      if (outFlit[1] !== f) begin
        bad++; $display("[TB] FAIL node5_flit dest=%b: got %h want %h", dests[k], outFlit[1], f);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] sent [6];
    logic [FW-1:0] accepted [$];
    logic [FW-1:0] want;
    outReady[0] = 5'b00000;
    for (int k = 0; k < 6; k++) begin
      sent[k]    = {7'($urandom), 4'($urandom)};
      inValid[0] = 1'b1;
      inFlit[0]  = sent[k];
      if (inReady[0] === 1'b1) accepted.push_back(sent[k]);
      tick();
    end
    inValid[0] = 1'b0;
    total++;
    if (accepted.size() != 5) begin
      bad++; $display("[TB] FAIL bp_accepted: got %0d want 5", accepted.size());
    end
    total++;
    if (inReady[0] !== 1'b0) begin
      bad++; $display("[TB] FAIL bp_in_ready: got %b want 0", inReady[0]);
    end
    total++;
    if (fifoCount[0] !== 3'd4) begin
      bad++; $display("[TB] FAIL bp_count: got %0d want 4", fifoCount[0]);
    end
    for (int c = 0; c < 3; c++) begin
      total++;
      if (outFlit[0] !== sent[0] || outValid[0] !== refPort(sent[0][3:0], 4'b0000)) begin
        bad++; $display("[TB] FAIL bp_stall_stable: got %h/%b want %h/%b", outFlit[0], outValid[0], sent[0], refPort(sent[0][3:0], 4'b0000));
      end
      tick();
    end
    outReady[0] = 5'b11111;
    for (int k = 0; k < 5; k++) begin
      want = sent[k];
      total++;
      if (outFlit[0] !== want || outValid[0] !== refPort(want[3:0], 4'b0000)) begin
        bad++; $display("[TB] FAIL bp_drain_%0d: got %h/%b want %h/%b", k, outFlit[0], outValid[0], want, refPort(want[3:0], 4'b0000));
      end
      tick();
    end
    total++;
    if (outValid[0] !== 5'b0 || fifoCount[0] !== 3'd0) begin
      bad++; $display("[TB] FAIL bp_empty: got valid=%b count=%0d want 00000/0", outValid[0], fifoCount[0]);
    end
  endtask

  task automatic test_hol_masking();
    logic [FW-1:0] a;
    logic [FW-1:0] b;
    a = {7'($urandom), 4'b0001};
    b = {7'($urandom), 4'b0010};
    outReady[0] = 5'b00100;
    inValid[0]  = 1'b1;
    inFlit[0]   = a;
    tick();
    inFlit[0] = b;
    tick();
    inValid[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (outValid[0] !== 5'b00010 || outFlit[0] !== a) begin
        bad++; $display("[TB] FAIL hol_blocked_%0d: got %b/%h want 00010/%h", c, outValid[0], outFlit[0], a);
      end
      if (c < 3) tick();
    end
    total++;
    if (fifoCount[0] !== 3'd1) begin
      bad++; $display("[TB] FAIL hol_count: got %0d want 1", fifoCount[0]);
    end
    outReady[0] = 5'b00010;
    tick();
    total++;
    if (outValid[0] !== 5'b00100 || outFlit[0] !== b) begin
      bad++; $display("[TB] FAIL hol_second: got %b/%h want 00100/%h", outValid[0], outFlit[0], b);
    end
    tick();
    total++;
    if (outValid[0] !== 5'b00100 || outFlit[0] !== b) begin
      bad++; $display("[TB] FAIL hol_mask: got %b/%h want 00100/%h", outValid[0], outFlit[0], b);
    end
    outReady[0] = 5'b00100;
    tick();
    total++;
    if (outValid[0] !== 5'b00000) begin
      bad++; $display("[TB] FAIL hol_drain: got %b want 00000", outValid[0]);
    end
  endtask

  task automatic test_reset_midstream();
    logic [FW-1:0] first;
    logic [FW-1:0] f;
    outReady[0] = 5'b00000;
    for (int k = 0; k < 4; k++) begin
      f = {7'($urandom), 4'($urandom)};
      if (k == 0) first = f;
      inValid[0] = 1'b1;
      inFlit[0]  = f;
      tick();
    end
    inValid[0] = 1'b0;
    total++;
    if (fifoCount[0] !== 3'd3 || outValid[0] !== refPort(first[3:0], 4'b0000)) begin
      bad++; $display("[TB] FAIL mid_preload: got count=%0d valid=%b want 3/%b", fifoCount[0], outValid[0], refPort(first[3:0], 4'b0000));
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (inReady[0] !== 1'b1 || outValid[0] !== 5'b0 || outFlit[0] !== 11'b0 || fifoCount[0] !== 3'd0) begin
      bad++; $display("[TB] FAIL mid_async_reset: got rdy=%b valid=%b flit=%h count=%0d want 1/00000/000/0", inReady[0], outValid[0], outFlit[0], fifoCount[0]);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    outReady[0] = 5'b11111;
    f = {7'($urandom), 4'b1000};
    inValid[0] = 1'b1;
    inFlit[0]  = f;
    tick();
    inValid[0] = 1'b0;
    total++;
    if (outValid[0] !== 5'b00000) begin
      bad++; $display("[TB] FAIL mid_no_stale: got %b want 00000", outValid[0]);
    end
    tick();
    total++;
    if (outValid[0] !== 5'b10000 || outFlit[0] !== f) begin
      bad++; $display("[TB] FAIL mid_after: got %b/%h want 10000/%h", outValid[0], outFlit[0], f);
    end
    tick();
    total++;
    if (outValid[0] !== 5'b00000 || fifoCount[0] !== 3'd0) begin
      bad++; $display("[TB] FAIL mid_empty: got %b/%0d want 00000/0", outValid[0], fifoCount[0]);
    end
  endtask

  // Random traffic against a queue of accepted-but-undelivered flits.
  task automatic test_random(input int u);
    logic [FW-1:0] q [$];
    logic [FW-1:0] want;
    logic [AW:0]   prevValid;
    logic [FW-1:0] prevFlit;
    logic          prevHeld;
    logic          xfer;
    int            inFlight;
    prevHeld  = 1'b0;
    prevValid = '0;
    prevFlit  = '0;
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        inValid[u] = ($urandom_range(0, 9) < 7);
        inFlit[u]  = FW'($urandom);
        for (int b = 0; b <= AW; b++) outReady[u][b] = ($urandom_range(0, 9) < 6);
      end else begin
        inValid[u]  = 1'b0;
        outReady[u] = 5'b11111;
      end
      total++;
      if (inReady[u] !== (fifoCount[u] != 3'd4)) begin
        bad++; $display("[TB] FAIL rnd_in_ready u%0d c%0d: got %b with count %0d", u, c, inReady[u], fifoCount[u]);
      end
      inFlight = int'(fifoCount[u]) + ((outValid[u] != 0) ? 1 : 0);
      total++;
      if (inFlight != q.size()) begin
        bad++; $display("[TB] FAIL rnd_occupancy u%0d c%0d: got %0d want %0d", u, c, inFlight, q.size());
      end
      if (outValid[u] != 0) begin
        total++;
        if (outValid[u] !== refPort(outFlit[u][3:0], nodeOf(u))) begin
          bad++; $display("[TB] FAIL rnd_route u%0d c%0d: got %b want %b", u, c, outValid[u], refPort(outFlit[u][3:0], nodeOf(u)));
        end
      end
      if (prevHeld) begin
        total++;
        if (outValid[u] !== prevValid || outFlit[u] !== prevFlit) begin
          bad++; $display("[TB] FAIL rnd_stable u%0d c%0d: got %b/%h want %b/%h", u, c, outValid[u], outFlit[u], prevValid, prevFlit);
        end
      end
      xfer = |(outValid[u] & outReady[u]);
      if (xfer) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("[TB] FAIL rnd_spurious u%0d c%0d: got %h want nothing", u, c, outFlit[u]);
        end else begin
          want = q.pop_front();
          if (outFlit[u] !== want) begin
            bad++; $display("[TB] FAIL rnd_order u%0d c%0d: got %h want %h", u, c, outFlit[u], want);
          end
        end
      end
      prevHeld  = (outValid[u] != 0) && !xfer;
      prevValid = outValid[u];
      prevFlit  = outFlit[u];
      if (inValid[u] && inReady[u]) q.push_back(inFlit[u]);
      tick();
    end
    total++;
    if (q.size() != 0 || outValid[u] !== 5'b0) begin
      bad++; $display("[TB] FAIL rnd_drain u%0d: got %0d left, valid=%b want 0/00000", u, q.size(), outValid[u]);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    for (int u = 0; u < 2; u++) begin
      inValid[u]  = 1'b0;
      inFlit[u]   = '0;
      outReady[u] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_core_delivery();
    test_lowest_bit();
    test_nonzero_node();
    test_backpressure();
    test_hol_masking();
    test_reset_midstream();
    test_random(1);
    test_random(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/route_compute_pipe.md
# route_compute_pipe

Clocked, parametrised successor to the handshake-driven path-computation stage in the NoC router. Accepts flits of `{payload, dest}` on a valid/ready input and buffers them in an internal FIFO. For each flit it computes the output port by XOR-ing `dest` with the node address: a match goes to the core port, otherwise the flit goes to the router port indexed by the lowest differing bit. It then presents the flit on a registered output stage with per-port valid/ready. It sits between the router input channel and the output arbiters.

## Interface
Parameters:
- `ADDR_W`, 4: destination address width; also the number of router ports.
- `DATA_W`, 7: payload width. Flit width `FLIT_W = DATA_W + ADDR_W`, laid out as `{payload, dest}` with `dest` in the LSBs.
- `NODE_ADDR`, `'0`: this node's address, `ADDR_W` bits.
- `DEPTH`, 4: input FIFO depth. Must be a power of two and at least 2.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `in_valid`, in, 1: input flit valid.
- `in_ready`, out, 1: input can accept. Equals `!fifo_full`, derived from registered count.
- `in_flit`, in, `FLIT_W`: input flit.
- `out_valid`, out, `ADDR_W+1`: one-hot port request. Bit 0 is the core; bit `i+1` is router port `i`.
- `out_ready`, in, `ADDR_W+1`: per-port ready.
- `out_flit`, out, `FLIT_W`: output flit, shared by all ports.
- `fifo_count`, out, `$clog2(DEPTH)+1`: current FIFO occupancy.

## Operation
- **Input transfer:** occurs when `in_valid && in_ready` at a rising edge; the flit is written to the FIFO tail.
- **Route decode:** combinational on the FIFO head.
  - `x = head.dest ^ NODE_ADDR`.
  - If `x == 0`, port 0 (core).
  - Otherwise port `p+1`, where `p` is the index of the lowest set bit of `x`.
- **Output stage:** one register holding the flit and its one-hot port. Two states:
  - IDLE: stage empty, `out_valid == 0`. If the FIFO is non-empty, load the head and the decoded port, then go to HOLD.
  - HOLD: `out_valid` is the stored one-hot. Transfer occurs when `|(out_valid & out_ready)`.
    - On transfer with the FIFO non-empty, load the next head in the same cycle and stay in HOLD.
    - On transfer with the FIFO empty, go to IDLE.
    - With no transfer, hold the flit.
- **Stall behaviour:** head-of-line blocking. A stalled port blocks all subsequent flits. `out_flit` and `out_valid` must stay stable while unaccepted.
- **Ready masking:** readiness on non-addressed ports is ignored.
- **FIFO boundaries:**
  - Simultaneous push and pop leaves `fifo_count` unchanged.
  - When full, `in_ready` is 0 even if a pop happens that cycle; there is no same-cycle refill.
  - Read and write pointers wrap modulo `DEPTH`.
  - No pop when empty.
- **Capacity:** total storage is `DEPTH + 1` flits.

## Timing
- **Reset values:** `in_ready = 1`, `out_valid = 0`, `out_flit = 0`, `fifo_count = 0`, pointers 0, stage in IDLE.
- **Reset mid-operation:** asynchronous assertion immediately forces these values. All buffered flits are discarded, with no partial output.
- **Latency:** a flit accepted at edge *t* into an empty pipe shows `out_valid` after edge *t+1*. Minimum latency is 2 edges.
- **Throughput:** 1 flit per cycle sustained when the addressed ports are ready.
- **Paths:** no combinational path from `in_valid` to `out_*`. `in_ready` does not depend on `out_ready` in the same cycle.

## Structure
- **Package `route_pkg`:**
  - `function automatic route_onehot(dest, node)`, returning the `ADDR_W+1` one-hot port.
  - Localparam `CORE_PORT = 0`.
  - Flit field slicing helpers.
- **Sub-module `sync_fifo`:** parametrised by `WIDTH` and `DEPTH`, with push/pop/full/empty/count. Instantiated once.
- **Top:** the output-stage FSM and decode are written in `route_compute_pipe` itself.

## Test plan
- **Core delivery:** `NODE_ADDR = 0000`, send `{7'b1111000, 4'b0000}` with all ready → `out_valid = 00001`, `out_flit = 11'b1111000_0000`, 2 edges after acceptance.
- **Lowest-bit routing:** dest `0001`, `0010`, `0100`, `1000` → `out_valid` = `00010`, `00100`, `01000`, `10000`. Dest `0110` → `00100`.
- **Non-zero node:** `NODE_ADDR = 0101`, dest `0101` → core (`00001`). Dest `0111` → `00100`.
- **Backpressure:** hold `out_ready = 0`, push 6 flits → 5 accepted, `in_ready = 0` with `fifo_count = 4`. Release ready → flits drained in order, one per cycle, `out_flit` stable during the stall.
- **Head-of-line and ready masking:** first flit to port 1 with only `out_ready[2]` high → no transfer, and the second flit (port 2) is not emitted until `out_ready[1]` goes high.
- **Reset mid-stream:** with 3 flits buffered and `out_valid` high, assert `rst` between edges → outputs go to reset values immediately. After release, a new flit routes correctly with 2-edge latency.
